// File: rtl/fusion_pkg.sv
// Shared parameters, saturation constants and FSM state type for the
// attention-weighted feature scaling stage.
package fusion_pkg;

  localparam int unsigned NUM_LANES  = 6;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned WEIGHT_W   = 64;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned OUT_W      = 512;
  localparam int unsigned LANE_CNT_W = $clog2(NUM_LANES);

  localparam logic [LANE_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [LANE_W-1:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    DONE
  } fusion_seq_state_t;

endpackage

// File: rtl/fusion_lane_scale.sv
// Combinational saturating Q16.16 scaler: 64-bit signed weight times one
// 32-bit signed lane, arithmetic shift right by FRAC_BITS, clamp to 32 bits.
module fusion_lane_scale
  import fusion_pkg::*;
(
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [LANE_W-1:0]   lane,
  output logic [LANE_W-1:0]   result,
  output logic                sat
);

  localparam int unsigned PROD_W = WEIGHT_W + LANE_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] sh;
  logic [PROD_W-LANE_W:0]   upper;

  always_comb begin
    prod  = $signed({{LANE_W{weight[WEIGHT_W-1]}}, weight})
          * $signed({{WEIGHT_W{lane[LANE_W-1]}}, lane});
    sh    = prod >>> FRAC_BITS;
    // Fits in 32 bits only when everything from bit 31 upward is a pure sign extension.
    upper = sh[PROD_W-1:LANE_W-1];
    sat   = !((&upper) || !(|upper));
    if (sat) begin
      result = sh[PROD_W-1] ? SAT_NEG : SAT_POS;
    end else begin
      result = sh[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/fusion_scale_sequencer.sv
// Accepts a weight plus a V vector, scales one lane per cycle through a single
// shared scaler, and presents the zero-padded fused feature downstream.
module fusion_scale_sequencer
  import fusion_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WEIGHT_W-1:0]           attention_weight,
  input  logic [NUM_LANES*LANE_W-1:0]   v_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              fused_feature,
  output logic [NUM_LANES-1:0]          sat_flags,
  output logic                          busy
);

  fusion_seq_state_t state, state_next;

  logic [LANE_CNT_W-1:0] lane_cnt;
  logic [WEIGHT_W-1:0]   hold_weight;
  logic [LANE_W-1:0]     hold_lane [NUM_LANES];
  logic [LANE_W-1:0]     work_lane [NUM_LANES];
  logic [NUM_LANES-1:0]  work_sat;

  logic [LANE_W-1:0]     lane_sel;
  logic [LANE_W-1:0]     scale_result;
  logic                  scale_sat;
  logic [NUM_LANES-1:0]  sat_next;
  logic [OUT_W-1:0]      fused_next;
  logic                  accept;
  logic                  last_lane;

  assign accept    = in_valid && in_ready;
  assign last_lane = (lane_cnt == LANE_CNT_W'(NUM_LANES - 1));
  assign lane_sel  = hold_lane[lane_cnt];

  fusion_lane_scale u_lane_scale (
    .weight (hold_weight),
    .lane   (lane_sel),
    .result (scale_result),
    .sat    (scale_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = SCALE;
      SCALE:   if (last_lane) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // The lane being scaled this cycle is merged in here so the final copy to
  // fused_feature includes it without an extra cycle.
  always_comb begin
    sat_next           = work_sat;
    sat_next[lane_cnt] = scale_sat;
    fused_next         = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      fused_next[i*LANE_W +: LANE_W] =
        (LANE_CNT_W'(i) == lane_cnt) ? scale_result : work_lane[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt      <= '0;
      hold_weight   <= '0;
      work_sat      <= '0;
      fused_feature <= '0;
      sat_flags     <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        hold_lane[i] <= '0;
        work_lane[i] <= '0;
      end
    end else if (accept) begin
      hold_weight <= attention_weight;
      lane_cnt    <= '0;
      work_sat    <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        hold_lane[i] <= v_in[i*LANE_W +: LANE_W];
      end
    end else if (state == SCALE) begin
      work_lane[lane_cnt] <= scale_result;
      work_sat            <= sat_next;
      if (last_lane) begin
        lane_cnt      <= '0;
        fused_feature <= fused_next;
        sat_flags     <= sat_next;
      end else begin
        lane_cnt <= lane_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fusion_scale_sequencer.sv
// Directed plus randomized bench for fusion_scale_sequencer, checked against
// an arithmetic reference of the saturating Q16.16 lane scaling.
module tb_fusion_scale_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  attention_weight;
  logic [191:0] v_in;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] fused_feature;
  logic [5:0]   sat_flags;
  logic         busy;

  int unsigned  n_asserts = 0;
  int unsigned  n_fail    = 0;
  logic [511:0] last_fused;
  logic [5:0]   last_sat;

  fusion_scale_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .attention_weight (attention_weight),
    .v_in             (v_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .fused_feature    (fused_feature),
    .sat_flags        (sat_flags),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Real-valued view: floor(w*x / 2^16), clamped to the signed 32-bit range.
  task automatic ref_vec(input logic [63:0] w, input logic [191:0] v,
                         output logic [511:0] f, output logic [5:0] s);
    logic signed [127:0] p;
    logic signed [127:0] q;
    logic [31:0] lane;
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    max_v = 128'sd2147483647;
    min_v = -128'sd2147483648;
    f = '0;
    s = '0;
    for (int i = 0; i < 6; i++) begin
      lane = v[i*32 +: 32];
      p = $signed({{64{w[63]}}, w}) * $signed({{96{lane[31]}}, lane});
      q = p >>> 16;
      if (q > max_v) begin
        f[i*32 +: 32] = 32'h7FFF_FFFF;
        s[i] = 1'b1;
      end else if (q < min_v) begin
        f[i*32 +: 32] = 32'h8000_0000;
        s[i] = 1'b1;
      end else begin
        f[i*32 +: 32] = q[31:0];
      end
    end
  endtask

  function automatic logic [191:0] rand_vec();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand_weight();
    logic [31:0] r;
    logic [63:0] w;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       w = {$urandom, $urandom};
      1:       w = {{32{r[31]}}, r};
      default: begin
        w = 64'($urandom_range(0, 32'h0003_FFFF));
        if ($urandom_range(0, 1) == 1) w = -w;
      end
    endcase
    return w;
  endfunction

  // Starts and ends at a falling edge; ends with the result on the outputs.
  task automatic scale_check(input logic [63:0] w, input logic [191:0] v, input string tag,
                             input bit hold, input logic [63:0] nw, input logic [191:0] nv);
    logic [511:0] ef;
    logic [5:0]   es;
    ref_vec(w, v, ef, es);
    check({tag, ":in_ready_idle"}, 512'(in_ready), 512'(1'b1));
    in_valid = 1'b1;
    attention_weight = w;
    v_in = v;
    @(posedge clk);
    #1;
    if (hold) begin
      attention_weight = nw;
      v_in = nv;
    end else begin
      in_valid = 1'b0;
      attention_weight = {$urandom, $urandom};
      v_in = rand_vec();
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 6) begin
        check({tag, ":out_valid_low"}, 512'(out_valid), 512'(1'b0));
        check({tag, ":in_ready_busy"}, 512'(in_ready), 512'(1'b0));
        check({tag, ":no_partial"}, fused_feature, last_fused);
      end else begin
        check({tag, ":out_valid_high"}, 512'(out_valid), 512'(1'b1));
        check({tag, ":fused"}, fused_feature, ef);
        check({tag, ":sat"}, 512'(sat_flags), 512'(es));
      end
    end
    last_fused = ef;
    last_sat = es;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ":hs_out_valid"}, 512'(out_valid), 512'(1'b0));
    check({tag, ":hs_in_ready"}, 512'(in_ready), 512'(1'b1));
    check({tag, ":hs_busy"}, 512'(busy), 512'(1'b0));
  endtask

  initial begin
    logic [63:0]  wa, wb, wc;
    logic [191:0] va, vb, vc;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    attention_weight = '0;
    v_in = '0;
    last_fused = '0;
    last_sat = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst:in_ready", 512'(in_ready), 512'(1'b1));
    check("rst:out_valid", 512'(out_valid), 512'(1'b0));
    check("rst:busy", 512'(busy), 512'(1'b0));
    check("rst:fused", fused_feature, '0);
    check("rst:sat", 512'(sat_flags), 512'(6'd0));
    rst_n = 1'b1;

    // Unity weight: lanes pass through unchanged
    va = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
          32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    scale_check(64'h0001_0000, va, "unity", 1'b0, '0, '0);
    check("unity:passthru", fused_feature, {320'd0, va});
    handshake("unity");

    // Half scale with floor rounding of a negative lane
    va = {128'd0, 32'h0003_0000, 32'hFFFE_0000};
    scale_check(64'h8000, va, "half", 1'b0, '0, '0);
    check("half:lane0", 512'(fused_feature[31:0]), 512'(32'hFFFF_0000));
    check("half:lane1", 512'(fused_feature[63:32]), 512'(32'h0001_8000));
    handshake("half");

    // Saturation in both directions
    va = {128'd0, 32'hFFFE_0000, 32'h0002_0000};
    scale_check(64'h7FFF_0000, va, "sat", 1'b0, '0, '0);
    check("sat:lane0", 512'(fused_feature[31:0]), 512'(32'h7FFF_FFFF));
    check("sat:lane1", 512'(fused_feature[63:32]), 512'(32'h8000_0000));
    check("sat:flags", 512'(sat_flags), 512'(6'b000011));
    handshake("sat");

    // Backpressure: result held while a new vector waits
    wa = rand_weight(); va = rand_vec();
    wb = rand_weight(); vb = rand_vec();
    out_ready = 1'b0;
    scale_check(wa, va, "bp_a", 1'b0, '0, '0);
    in_valid = 1'b1;
    attention_weight = wb;
    v_in = vb;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp:out_valid_held", 512'(out_valid), 512'(1'b1));
      check("bp:fused_held", fused_feature, last_fused);
      check("bp:sat_held", 512'(sat_flags), 512'(last_sat));
      check("bp:in_ready_low", 512'(in_ready), 512'(1'b0));
    end
    handshake("bp_a");
    scale_check(wb, vb, "bp_b", 1'b0, '0, '0);
    handshake("bp_b");

    // Reset while lane 3 is being scaled
    check("mid:in_ready_idle", 512'(in_ready), 512'(1'b1));
    in_valid = 1'b1;
    attention_weight = rand_weight();
    v_in = rand_vec();
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid:busy_before", 512'(busy), 512'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid:in_ready", 512'(in_ready), 512'(1'b1));
    check("mid:out_valid", 512'(out_valid), 512'(1'b0));
    check("mid:busy", 512'(busy), 512'(1'b0));
    check("mid:fused", fused_feature, '0);
    check("mid:sat", 512'(sat_flags), 512'(6'd0));
    last_fused = '0;
    last_sat = '0;
    repeat (3) begin
      @(negedge clk);
      check("mid:no_out_valid", 512'(out_valid), 512'(1'b0));
    end
    rst_n = 1'b1;
    wc = rand_weight(); vc = rand_vec();
    scale_check(wc, vc, "post_rst", 1'b0, '0, '0);
    handshake("post_rst");

    // Back-to-back with in_valid held high: one accept every 8 cycles
    wa = rand_weight(); va = rand_vec();
    wb = rand_weight(); vb = rand_vec();
    wc = rand_weight(); vc = rand_vec();
    scale_check(wa, va, "b2b_0", 1'b1, wb, vb);
    handshake("b2b_0");
    scale_check(wb, vb, "b2b_1", 1'b1, wc, vc);
    handshake("b2b_1");
    scale_check(wc, vc, "b2b_2", 1'b0, '0, '0);
    handshake("b2b_2");

    // Randomized vectors
    for (int n = 0; n < 16; n++) begin
      wa = rand_weight();
      va = rand_vec();
      scale_check(wa, va, "rand", 1'b0, '0, '0);
      handshake("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
